// File: rtl/emu_ram_scan_ctrl.sv
// RAM scan-chain sequencer for checkpoint save/load: pauses the target, pulses the
// scan pointer reset, streams CHAIN_WORDS words out or in. Optional: EMU_SCAN_CHECKSUM_EN.
module emu_ram_scan_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHAIN_WORDS   = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  host_clk,
  input  logic                  host_rst,
  input  logic                  run_en,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_load,
  output logic                  done,
  output logic                  sdo_valid,
  input  logic                  sdo_ready,
  output logic [DATA_WIDTH-1:0] sdo_data,
  input  logic                  sdi_valid,
  output logic                  sdi_ready,
  input  logic [DATA_WIDTH-1:0] sdi_data,
  output logic                  run_mode,
  output logic                  scan_mode,
  output logic                  ram_sr,
  output logic                  ram_se,
  output logic                  ram_sd,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
`ifdef EMU_SCAN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] chk_sum,
  output logic                  chk_valid
`endif
);

  localparam int CNT_W = $clog2(CHAIN_WORDS + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(CHAIN_WORDS - 1);
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PAUSE, S_SRST, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic             r_op;
  logic [SET_W-1:0] r_settle;
  logic [CNT_W-1:0] r_wcnt;
  logic             w_shift;
  logic             w_accept;
  logic             w_se;
  logic             w_last;

  assign w_shift  = (r_state == S_SHIFT);
  assign w_accept = cmd_valid && cmd_ready;
  // The stream handshake is the shift enable itself: no buffering between host and chain.
  assign w_se     = w_shift && (r_op ? sdi_valid : sdo_ready);
  assign w_last   = (r_wcnt == LAST_WORD);

  assign cmd_ready = (r_state == S_IDLE);
  assign run_mode  = (r_state == S_IDLE) && run_en;
  assign scan_mode = (r_state != S_IDLE);
  assign ram_sr    = (r_state == S_SRST);
  assign ram_se    = w_se;
  assign ram_sd    = w_shift && r_op;
  assign done      = (r_state == S_DONE);
  assign sdo_valid = w_shift && !r_op;
  assign sdi_ready = w_shift && r_op;
  assign sdo_data  = ram_do;
  assign ram_di    = sdi_data;

  always_ff @(posedge host_clk or posedge host_rst) begin
    if (host_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 1'b0;
      r_settle <= '0;
      r_wcnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= cmd_load;
            r_settle <= SETTLE_INIT;
            r_state  <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (r_settle == '0) r_state <= S_SRST;
          else                r_settle <= r_settle - SET_W'(1);
        end
        S_SRST: begin
          r_wcnt  <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_se) begin
            r_wcnt <= r_wcnt + CNT_W'(1);
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef EMU_SCAN_CHECKSUM_EN
  // Running sum of every word crossing the chain boundary, valid from DONE until the next accept.
  always_ff @(posedge host_clk or posedge host_rst) begin
    if (host_rst) begin
      chk_sum   <= '0;
      chk_valid <= 1'b0;
    end else begin
      if (r_state == S_SRST) chk_sum <= '0;
      else if (w_se)         chk_sum <= chk_sum + (r_op ? sdi_data : ram_do);
      if (w_accept)                 chk_valid <= 1'b0;
      else if (w_se && w_last)      chk_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_emu_ram_scan_ctrl.sv
// Scoreboard bench for emu_ram_scan_ctrl with a behavioural RAM scan chain model.
// Build with EMU_SCAN_CHECKSUM_EN defined to also exercise the checksum outputs.
module tb_emu_ram_scan_ctrl;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_en = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_load = 1'b0;
  logic          sdo_ready = 1'b0;
  logic          sdi_valid = 1'b0;
  logic [DW-1:0] sdi_data = '0;
  logic          cmd_ready, done, sdo_valid, sdi_ready;
  logic          run_mode, scan_mode, ram_sr, ram_se, ram_sd;
  logic [DW-1:0] sdo_data, ram_di, ram_do;
`ifdef EMU_SCAN_CHECKSUM_EN
  logic [DW-1:0] chk_sum;
  logic          chk_valid;
`endif

  emu_ram_scan_ctrl #(.DATA_WIDTH(DW), .CHAIN_WORDS(CW), .SETTLE_CYCLES(SC)) dut (
    .host_clk(clk), .host_rst(rst), .run_en(run_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .done(done),
    .sdo_valid(sdo_valid), .sdo_ready(sdo_ready), .sdo_data(sdo_data),
    .sdi_valid(sdi_valid), .sdi_ready(sdi_ready), .sdi_data(sdi_data),
    .run_mode(run_mode), .scan_mode(scan_mode), .ram_sr(ram_sr), .ram_se(ram_se),
    .ram_sd(ram_sd), .ram_di(ram_di), .ram_do(ram_do)
`ifdef EMU_SCAN_CHECKSUM_EN
    , .chk_sum(chk_sum), .chk_valid(chk_valid)
`endif
  );

  always #5 clk = ~clk;

  logic [3:0][63:0] A = {64'h8000_0000_0000_0000, 64'h0000_0000_0000_0055,
                         64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
  logic [3:0][63:0] L = {64'hCAFE_F00D_0000_0004, 64'hDEAD_BEEF_0000_0003,
                         64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};

  // Emulated system's RAM scan chain: pointer reset by ram_sr, one word per ram_se.
  logic [3:0][63:0] mem = {64'h8000_0000_0000_0000, 64'h0000_0000_0000_0055,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
  logic [1:0] ptr = 2'd0;
  always @(posedge clk) begin
    if (ram_sr) ptr <= 2'd0;
    else if (ram_se) begin
      if (ram_sd) mem[ptr] <= ram_di;
      ptr <= ptr + 2'd1;
    end
  end
  assign ram_do = mem[ptr];

  int n_chk = 0;
  int n_pass = 0;
  int se_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur within budget", name);
  endtask

  function automatic logic [63:0] sum4(input logic [3:0][63:0] w);
    return w[0] + w[1] + w[2] + w[3];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a word or a done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_sr || ram_se) check("sr_se_exclusive", 64'(ram_sr && ram_se), 64'd0);
      if (scan_mode) check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      if (sdo_valid && sdo_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sdo_unexpected: got %0h expected none", sdo_data);
        end else check("sdo_data", sdo_data, exp_q.pop_front());
        check("sdo_eq_ram_do", sdo_data, ram_do);
      end
      if (ram_se) begin
        se_cnt++;
        if (ram_sd) begin
          check("se_needs_sdi_valid", 64'(sdi_valid), 64'd1);
          check("ram_di", ram_di, sdi_data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
`ifdef EMU_SCAN_CHECKSUM_EN
          check("chk_valid_at_done", 64'(chk_valid), 64'd1);
          check("chk_sum_at_done", chk_sum, done_q.pop_front());
`else
          void'(done_q.pop_front());
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic load);
    cmd_valid = 1'b1;
    cmd_load  = load;
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
      tick();
    end
    if (k == budget) fail_now(name);
    tick();
  endtask

  // Expected {run_mode,scan_mode,ram_sr,ram_se,done,cmd_ready} for T+1..T+9 with sdo_ready=1.
  task automatic timed_save(input string tag);
    logic [5:0] ev [9] = '{6'b010000, 6'b010000, 6'b011000, 6'b010100, 6'b010100,
                           6'b010100, 6'b010100, 6'b010010, 6'b100001};
    issue(1'b0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("%s_T+%0d", tag, k + 1),
            64'({run_mode, scan_mode, ram_sr, ram_se, done, cmd_ready}), 64'(ev[k]));
      tick();
    end
  endtask

  task automatic load_words(input logic [3:0][63:0] w, input int gap, input string name);
    int k;
    issue(1'b1);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sdi_ready) break;
      tick();
    end
    if (k == 20) fail_now(name);
    tick();
    for (int i = 0; i < 4; i++) begin
      repeat (gap) tick();
      sdi_valid = 1'b1;
      sdi_data  = w[i];
      tick();
      sdi_valid = 1'b0;
    end
    wait_done(name, 20);
  endtask

  initial begin
    int se0;
    int k;
    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_outputs", 64'({run_mode, scan_mode, cmd_ready, ram_sr, ram_se, ram_sd,
                              done, sdo_valid, sdi_ready}), 64'b101000000);
`ifdef EMU_SCAN_CHECKSUM_EN
    check("rst_chk", 64'({chk_valid, chk_sum}), 64'd0);
`endif
    run_en = 1'b0;
    #1 check("rst_run_mode_follows_run_en", 64'(run_mode), 64'd0);
    run_en = 1'b1;
    tick();
    rst = 1'b0;

    // Timed save of the preset chain contents
    for (int i = 0; i < 4; i++) exp_q.push_back(A[i]);
    done_q.push_back(sum4(A));
    sdo_ready = 1'b1;
    timed_save("save_timing");

    // Load with 3-cycle gaps, then read back with sdo_ready stalls
    done_q.push_back(sum4(L));
    se0 = se_cnt;
    load_words(L, 3, "load_gapped");
    check("load_shift_count", 64'(se_cnt - se0), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("load_mem%0d", i), mem[i], L[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(L[i]);
    done_q.push_back(sum4(L));
    issue(1'b0);
    for (k = 0; k < 60; k++) begin
      sdo_ready = (k % 3 != 1);
      @(negedge clk);
      if (done) break;
      tick();
    end
    if (k == 60) fail_now("save_stalled_done");
    tick();
    sdo_ready = 1'b1;
    check("save_stalled_drained", 64'(exp_q.size()), 64'd0);

    // Command held during a transfer: second accept only in IDLE after done
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(L[i]);
      done_q.push_back(sum4(L));
    end
    cmd_valid = 1'b1;
    cmd_load  = 1'b0;
    tick();
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) break;
      tick();
    end
    if (k == 30) fail_now("held_cmd_first_done");
    tick();
    @(negedge clk);
    check("held_cmd_second_accept", 64'({cmd_ready, scan_mode}), 64'b10);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("held_cmd_busy_again", 64'({cmd_ready, scan_mode}), 64'b01);
    wait_done("held_cmd_second_done", 30);
    check("held_cmd_drained", 64'(exp_q.size()), 64'd0);

    // Reset during word 2 of a save, then restart
    exp_q.push_back(L[0]);
    exp_q.push_back(L[1]);
    issue(1'b0);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sdo_valid) break;
      tick();
    end
    if (k == 20) fail_now("abort_first_word");
    tick();
    tick();
    rst = 1'b1;
    #1 check("abort_same_cycle", 64'({scan_mode, ram_se, cmd_ready, sdo_valid}), 64'b0010);
    tick();
    rst = 1'b0;
    check("abort_words_seen", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(L[i]);
    done_q.push_back(sum4(L));
    timed_save("restart_timing");

`ifdef EMU_SCAN_CHECKSUM_EN
    done_q.push_back(64'd5);
    load_words({64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd2, 64'd1}, 0, "chk_load");
    check("chk_valid_held_idle", 64'(chk_valid), 64'd1);
`endif

    repeat (2) tick();
    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_done_q_empty", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
